// File: rtl/stereo_pkg.sv
// Shared constants and types for the stereo block-matching pipeline.
package stereo_pkg;

  localparam int SSD_WIDTH  = 23;
  localparam int NUM_DISP   = 16;
  localparam int DISP_WIDTH = $clog2(NUM_DISP);
  localparam int BLOCK_SIZE = 6;
  localparam int IMG_W      = 240;
  localparam int IMG_H      = 320;

  typedef logic [SSD_WIDTH-1:0]  ssd_t;
  typedef logic [DISP_WIDTH-1:0] disp_t;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    EMIT
  } wta_state_t;

endpackage

// File: rtl/ssd_top2_update.sv
// Combinational best/second-best tracker step for one incoming SSD candidate.
module ssd_top2_update #(
  parameter int SSD_WIDTH  = 23,
  parameter int DISP_WIDTH = 4
) (
  input  logic [SSD_WIDTH-1:0]  best_i,
  input  logic [SSD_WIDTH-1:0]  second_i,
  input  logic [DISP_WIDTH-1:0] bestDisp_i,
  input  logic [SSD_WIDTH-1:0]  ssd_i,
  input  logic [DISP_WIDTH-1:0] disp_i,
  output logic [SSD_WIDTH-1:0]  best_o,
  output logic [SSD_WIDTH-1:0]  second_o,
  output logic [DISP_WIDTH-1:0] bestDisp_o
);

  // Strict compares: an equal SSD neither steals the win nor displaces second.
  always_comb begin
    best_o     = best_i;
    second_o   = second_i;
    bestDisp_o = bestDisp_i;
    if (ssd_i < best_i) begin
      second_o   = best_i;
      best_o     = ssd_i;
      bestDisp_o = disp_i;
    end else if (ssd_i < second_i) begin
      second_o = ssd_i;
    end
  end

endmodule

// File: rtl/disparity_wta_select.sv
// Winner-take-all disparity selection over a serial stream of block SSDs,
// with a uniqueness confidence flag and valid/ready result handshake.
module disparity_wta_select #(
  parameter int SSD_WIDTH   = stereo_pkg::SSD_WIDTH,
  parameter int NUM_DISP    = stereo_pkg::NUM_DISP,
  parameter int DISP_WIDTH  = $clog2(NUM_DISP),
  parameter int COORD_WIDTH = 9,
  parameter int UNIQ_SHIFT  = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [COORD_WIDTH-1:0] block_x_in,
  input  logic [COORD_WIDTH-1:0] block_y_in,
  input  logic                   ssd_valid_in,
  input  logic [SSD_WIDTH-1:0]   ssd_in,
  output logic                   ready_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [DISP_WIDTH-1:0]  disparity_out,
  output logic [SSD_WIDTH-1:0]   min_ssd_out,
  output logic                   confident_out,
  output logic [COORD_WIDTH-1:0] block_x_out,
  output logic [COORD_WIDTH-1:0] block_y_out,
  output logic                   protocol_err_out
);

  import stereo_pkg::*;

  localparam logic [DISP_WIDTH:0] LAST_COUNT = (DISP_WIDTH+1)'(NUM_DISP - 1);
  localparam logic [DISP_WIDTH:0] COUNT_ONE  = (DISP_WIDTH+1)'(1);

  wta_state_t state_q, state_d;

  logic [DISP_WIDTH:0]    count_q;
  logic [SSD_WIDTH-1:0]   best_q, second_q;
  logic [DISP_WIDTH-1:0]  bestDisp_q;
  logic [COORD_WIDTH-1:0] blockX_q, blockY_q;
  logic [DISP_WIDTH-1:0]  resDisp_q;
  logic [SSD_WIDTH-1:0]   resSsd_q;
  logic                   resConf_q;
  logic                   protErr_q, protErr_d;

  logic [SSD_WIDTH-1:0]  bestNext, secondNext;
  logic [DISP_WIDTH-1:0] bestDispNext;
  logic [SSD_WIDTH:0]    margin;
  logic                  confNext;
  logic                  lastSample;

  ssd_top2_update #(
    .SSD_WIDTH (SSD_WIDTH),
    .DISP_WIDTH(DISP_WIDTH)
  ) u_top2 (
    .best_i    (best_q),
    .second_i  (second_q),
    .bestDisp_i(bestDisp_q),
    .ssd_i     (ssd_in),
    .disp_i    (count_q[DISP_WIDTH-1:0]),
    .best_o    (bestNext),
    .second_o  (secondNext),
    .bestDisp_o(bestDispNext)
  );

  // One extra bit on the margin so an all-ones best cannot wrap into "confident".
  assign margin     = {1'b0, bestNext} + {1'b0, (bestNext >> UNIQ_SHIFT)};
  assign confNext   = (margin < {1'b0, secondNext});
  assign lastSample = (count_q == LAST_COUNT);
  assign protErr_d  = (ssd_valid_in && (state_q != SEARCH)) ||
                      (start_in && (state_q != IDLE));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_in) state_d = SEARCH;
      SEARCH:  if (ssd_valid_in && lastSample) state_d = EMIT;
      EMIT:    if (ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state_q == IDLE);
    valid_out = (state_q == EMIT);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q    <= '0;
      best_q     <= '1;
      second_q   <= '1;
      bestDisp_q <= '0;
      blockX_q   <= '0;
      blockY_q   <= '0;
      resDisp_q  <= '0;
      resSsd_q   <= '0;
      resConf_q  <= 1'b0;
      protErr_q  <= 1'b0;
    end else begin
      protErr_q <= protErr_d;
      if ((state_q == IDLE) && start_in) begin
        blockX_q   <= block_x_in;
        blockY_q   <= block_y_in;
        best_q     <= '1;
        second_q   <= '1;
        bestDisp_q <= '0;
        count_q    <= '0;
      end else if ((state_q == SEARCH) && ssd_valid_in) begin
        best_q     <= bestNext;
        second_q   <= secondNext;
        bestDisp_q <= bestDispNext;
        count_q    <= count_q + COUNT_ONE;
        if (lastSample) begin
          resDisp_q <= bestDispNext;
          resSsd_q  <= bestNext;
          resConf_q <= confNext;
        end
      end
    end
  end

  assign disparity_out    = resDisp_q;
  assign min_ssd_out      = resSsd_q;
  assign confident_out    = resConf_q;
  assign block_x_out      = blockX_q;
  assign block_y_out      = blockY_q;
  assign protocol_err_out = protErr_q;

endmodule
